// File: rtl/change_capture.sv
// change_capture: samples a narrow bus every clock and logs the initial
// value plus every later change as {timestamp, value} in a show-ahead FIFO.
//
// Ports:
//   clk, rst_n       rising-edge clock, async active-low reset
//   en               capture enable (timer runs regardless)
//   din              observed nets
//   out_valid/ready  head handshake; out_time/out_data show the head
//   level            FIFO occupancy, DEPTH when full
//   overflow         sticky drop flag
//   drop_count       dropped entries, saturating at 255
module change_capture #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int TW    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [WIDTH-1:0]         din,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TW-1:0]            out_time,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [TW-1:0]    timer;
   logic             primed;
   logic [WIDTH-1:0] last_val;

   logic [TW-1:0]    mem_t [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;

   logic push_req;
   logic full;
   logic pop;
   logic do_write;
   logic drop;

   assign out_valid = (cnt != '0);
   assign full      = (cnt == FULL_LVL);
   assign pop       = out_valid && out_ready;
   assign push_req  = en && (!primed || (din != last_val));
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign do_write  = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;

   assign level    = cnt;
   assign out_time = mem_t[rd_ptr];
   assign out_data = mem_d[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer    <= '0;
         primed   <= 1'b0;
         last_val <= '0;
      end else begin
         timer <= timer + TW'(1);
         if (en) begin
            last_val <= din;
            primed   <= 1'b1;
         end
      end
   end

   // Storage is reset so the head outputs read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_t[i] <= '0;
            mem_d[i] <= '0;
         end
         wr_ptr <= '0;
      end else if (do_write) begin
         mem_t[wr_ptr] <= timer;
         mem_d[wr_ptr] <= din;
         wr_ptr        <= wr_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_write, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_change_capture.sv
// tb_change_capture: table vectors plus a scoreboard queue for the
// change_capture FIFO; inputs change and outputs are sampled on negedge.
module tb_change_capture;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  din;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_time;
   logic [1:0]  out_data;
   logic [2:0]  level;
   logic        overflow;
   logic [7:0]  drop_count;

   change_capture #(.WIDTH(2), .DEPTH(4), .TW(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_time(out_time), .out_data(out_data),
      .level(level), .overflow(overflow), .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] t;
      logic [1:0]  d;
   } entry_t;

   typedef struct {
      logic        en;
      logic [1:0]  din;
      logic        rdy;
      int          lvl;
      logic        vld;
      int          tm;
      logic [1:0]  dat;
      int          drops;
   } vec_t;

   entry_t      sb[$];
   logic [15:0] tcount;
   logic        m_primed;
   logic [1:0]  m_last;
   logic        m_ovf;
   int          m_drops;
   int          n_cmp;
   int          n_bad;
   vec_t        vec[18];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      tcount   = '0;
      m_primed = 1'b0;
      m_last   = 2'b00;
      m_ovf    = 1'b0;
      m_drops  = 0;
   endtask

   task automatic check_now();
      chk("out_valid", out_valid, (sb.size() != 0));
      chk("level", level, sb.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drops);
      if (sb.size() != 0) begin
         chk("sb_time", out_time, sb[0].t);
         chk("sb_data", out_data, sb[0].d);
      end
   endtask

   // One clock: drive at negedge, predict the edge, sample next negedge.
   task automatic step(input logic e, input logic [1:0] d,
                       input logic r);
      logic   push;
      logic   pop;
      int     pre;
      entry_t ent;
      en        = e;
      din       = d;
      out_ready = r;
      push = e && (!m_primed || (d != m_last));
      pre  = sb.size();
      pop  = r && (pre != 0);
      if (e) begin
         m_last   = d;
         m_primed = 1'b1;
      end
      if (pop) void'(sb.pop_front());
      if (push) begin
         if (pre < 4 || pop) begin
            ent.t = tcount;
            ent.d = d;
            sb.push_back(ent);
         end else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
      end
      tcount = tcount + 16'd1;
      @(posedge clk);
      @(negedge clk);
      check_now();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      en = 1'b0;
      din = 2'b00;
      out_ready = 1'b0;
      model_reset();

      // Change sequence, overflow, full push+pop, drain.
      vec[0]  = '{1'b1, 2'b01, 1'b0, 1, 1'b1, 0,  2'b01, 0};
      vec[1]  = '{1'b1, 2'b00, 1'b0, 2, 1'b1, 0,  2'b01, 0};
      vec[2]  = '{1'b1, 2'b00, 1'b0, 2, 1'b1, 0,  2'b01, 0};
      vec[3]  = '{1'b1, 2'b00, 1'b1, 1, 1'b1, 1,  2'b00, 0};
      vec[4]  = '{1'b1, 2'b00, 1'b1, 0, 1'b0, 0,  2'b00, 0};
      vec[5]  = '{1'b1, 2'b00, 1'b1, 0, 1'b0, 0,  2'b00, 0};
      vec[6]  = '{1'b1, 2'b11, 1'b0, 1, 1'b1, 6,  2'b11, 0};
      vec[7]  = '{1'b1, 2'b00, 1'b0, 2, 1'b1, 6,  2'b11, 0};
      vec[8]  = '{1'b1, 2'b11, 1'b0, 3, 1'b1, 6,  2'b11, 0};
      vec[9]  = '{1'b1, 2'b00, 1'b0, 4, 1'b1, 6,  2'b11, 0};
      vec[10] = '{1'b1, 2'b11, 1'b0, 4, 1'b1, 6,  2'b11, 1};
      vec[11] = '{1'b1, 2'b00, 1'b0, 4, 1'b1, 6,  2'b11, 2};
      vec[12] = '{1'b1, 2'b11, 1'b0, 4, 1'b1, 6,  2'b11, 3};
      vec[13] = '{1'b1, 2'b00, 1'b1, 4, 1'b1, 7,  2'b00, 3};
      vec[14] = '{1'b1, 2'b00, 1'b1, 3, 1'b1, 8,  2'b11, 3};
      vec[15] = '{1'b1, 2'b00, 1'b1, 2, 1'b1, 9,  2'b00, 3};
      vec[16] = '{1'b1, 2'b00, 1'b1, 1, 1'b1, 13, 2'b00, 3};
      vec[17] = '{1'b1, 2'b00, 1'b1, 0, 1'b0, 0,  2'b00, 3};

      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_level", level, 3'd0);
      chk("rst_time", out_time, 16'd0);
      chk("rst_data", out_data, 2'b00);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_drops", drop_count, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step(vec[i].en, vec[i].din, vec[i].rdy);
         chk("vec_level", level, vec[i].lvl);
         chk("vec_valid", out_valid, vec[i].vld);
         chk("vec_drops", drop_count, vec[i].drops);
         if (vec[i].vld) begin
            chk("vec_time", out_time, vec[i].tm);
            chk("vec_data", out_data, vec[i].dat);
         end
      end
      chk("vec_ovf", overflow, 1'b1);

      // Enable gating: excursion while disabled leaves nothing behind.
      step(1'b1, 2'b01, 1'b1);
      step(1'b0, 2'b10, 1'b1);
      step(1'b0, 2'b01, 1'b1);
      step(1'b1, 2'b01, 1'b1);
      chk("gate_level0", level, 3'd0);
      step(1'b0, 2'b10, 1'b0);
      step(1'b0, 2'b10, 1'b0);
      step(1'b1, 2'b10, 1'b0);
      chk("gate_time", out_time, 16'd24);
      chk("gate_data", out_data, 2'b10);
      chk("gate_level1", level, 3'd1);

      // Async reset with three entries queued.
      step(1'b1, 2'b01, 1'b0);
      step(1'b1, 2'b10, 1'b0);
      chk("pre_rst_level", level, 3'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_level", level, 3'd0);
      chk("arst_ovf", overflow, 1'b0);
      chk("arst_drops", drop_count, 8'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 2'b11, 1'b0);
      chk("post_rst_time", out_time, 16'd0);
      chk("post_rst_data", out_data, 2'b11);

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 1'b0);
      end
      chk("sat_drops", drop_count, 8'd255);
      chk("sat_level", level, 3'd4);
      for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1);
      chk("sat_drained", out_valid, 1'b0);
      chk("sat_sticky", drop_count, 8'd255);

      // Timer wrap: entries stamped FFFF then 0.
      while (tcount != 16'hFFFF) step(1'b0, 2'b00, 1'b1);
      step(1'b1, 2'b01, 1'b1);
      chk("wrap_hi", out_time, 16'hFFFF);
      step(1'b1, 2'b10, 1'b0);
      chk("wrap_level", level, 3'd2);
      step(1'b0, 2'b10, 1'b1);
      chk("wrap_lo", out_time, 16'd0);
      chk("wrap_data", out_data, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
